// File: rtl/neuron_step_scheduler_if.sv
// Datapath handshake and spike-FIFO pop port of neuron_step_scheduler.
// master = scheduler side, slave = shared neuron datapath / spike consumer.
interface neuron_step_scheduler_if #(
  parameter int IW    = 3,
  parameter int WIDTH = 18
);
  logic                    dp_req;
  logic [IW-1:0]           dp_idx;
  logic signed [WIDTH-1:0] dp_v;
  logic signed [WIDTH-1:0] dp_i;
  logic                    dp_ack;
  logic signed [WIDTH-1:0] dp_v_next;
  logic                    spk_valid;
  logic [IW-1:0]           spk_idx;
  logic                    spk_ready;
  logic                    spk_drop;

  modport master (
    output dp_req, dp_idx, dp_v, dp_i,
    input  dp_ack, dp_v_next,
    output spk_valid, spk_idx, spk_drop,
    input  spk_ready
  );

  modport slave (
    input  dp_req, dp_idx, dp_v, dp_i,
    output dp_ack, dp_v_next,
    input  spk_valid, spk_idx, spk_drop,
    output spk_ready
  );
endinterface

// File: rtl/neuron_step_scheduler.sv
// Sweeps N_NEURONS stored membrane states through one shared datapath per step,
// resets spiking neurons and queues their indices. Option: NEURON_SCHED_REFRACTORY_EN.
module neuron_step_scheduler #(
  parameter int                      N_NEURONS  = 8,
  parameter int                      WIDTH      = 18,
  parameter logic signed [WIDTH-1:0] V_THRESH   = 18'sd4096,
  parameter logic signed [WIDTH-1:0] V_RESET    = '0,
  parameter int                      FIFO_DEPTH = 4,
`ifdef NEURON_SCHED_REFRACTORY_EN
  parameter int                      REFRAC_STEPS = 3,
`endif
  localparam int                     IW = $clog2(N_NEURONS)
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst_n,
  input  logic                    step,
  output logic                    busy,
  output logic                    step_done,
  input  logic                    i_wr_en,
  input  logic [IW-1:0]           i_wr_addr,
  input  logic signed [WIDTH-1:0] i_wr_data,
  neuron_step_scheduler_if.master dp
);

  typedef enum logic [1:0] {IDLE, REQ, WB, DONE} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic signed [WIDTH-1:0] r_v [N_NEURONS];
  logic signed [WIDTH-1:0] r_i [N_NEURONS];
  logic signed [WIDTH-1:0] r_vnext;
  logic                    r_skip;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_req;
  logic [IW-1:0]           r_dp_idx;
  logic signed [WIDTH-1:0] r_dp_v;
  logic signed [WIDTH-1:0] r_dp_i;

  logic [IW-1:0]           r_fifo [FIFO_DEPTH];
  logic [PW:0]             r_wp;
  logic [PW:0]             r_rp;
  logic                    r_drop;

  logic                    w_last;
  logic                    w_enter;
  logic [IW-1:0]           w_slot_idx;
  logic                    w_slot_skip;
  logic                    w_spike;
  logic                    w_push;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_accept;
  logic [PW:0]             w_count;

  assign w_last     = (r_idx == IW'(N_NEURONS - 1));
  assign w_enter    = ((r_state == IDLE) && step) || ((r_state == WB) && !w_last);
  assign w_slot_idx = (r_state == IDLE) ? '0 : r_idx + IW'(1);
  assign w_spike    = (r_vnext >= V_THRESH);
  assign w_push     = (r_state == WB) && !r_skip && w_spike;

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) r_i[k] <= '0;
    end else if (i_wr_en) begin
      r_i[i_wr_addr] <= i_wr_data;
    end
  end

  // Operands are captured on slot entry, so current writes landing during REQ
  // only take effect at the next step.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_vnext  <= '0;
      r_skip   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_req    <= 1'b0;
      r_dp_idx <= '0;
      r_dp_v   <= '0;
      r_dp_i   <= '0;
      for (int unsigned k = 0; k < N_NEURONS; k++) r_v[k] <= V_RESET;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: if (step) r_busy <= 1'b1;
        REQ: begin
          if (dp.dp_ack) begin
            r_vnext <= dp.dp_v_next;
            r_req   <= 1'b0;
            r_state <= WB;
          end
        end
        WB: begin
          r_v[r_idx] <= (r_skip || w_spike) ? V_RESET : r_vnext;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_enter) begin
        r_idx    <= w_slot_idx;
        r_dp_idx <= w_slot_idx;
        r_dp_v   <= r_v[w_slot_idx];
        r_dp_i   <= r_i[w_slot_idx];
        r_skip   <= w_slot_skip;
        r_req    <= !w_slot_skip;
        r_state  <= w_slot_skip ? WB : REQ;
      end
    end
  end

`ifdef NEURON_SCHED_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 1);

  logic [RW-1:0] r_ref [N_NEURONS];

  assign w_slot_skip = (r_ref[w_slot_idx] != '0);

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) r_ref[k] <= '0;
    end else if (r_state == WB) begin
      if (r_skip)       r_ref[r_idx] <= r_ref[r_idx] - RW'(1);
      else if (w_spike) r_ref[r_idx] <= RW'(REFRAC_STEPS);
    end
  end
`else
  assign w_slot_skip = 1'b0;
`endif

  // Extra pointer bit distinguishes full from empty.
  assign w_count  = r_wp - r_rp;
  assign w_empty  = (r_wp == r_rp);
  assign w_full   = (w_count == (PW + 1)'(FIFO_DEPTH));
  assign w_pop    = !w_empty && dp.spk_ready;
  assign w_accept = w_push && (!w_full || w_pop);

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_drop <= 1'b0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) r_fifo[k] <= '0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wp[PW-1:0]] <= r_idx;
        r_wp                 <= r_wp + (PW + 1)'(1);
      end
      if (w_pop) r_rp <= r_rp + (PW + 1)'(1);
      if (w_push && !w_accept) r_drop <= 1'b1;
    end
  end

  assign busy         = r_busy;
  assign step_done    = r_done;
  assign dp.dp_req    = r_req;
  assign dp.dp_idx    = r_dp_idx;
  assign dp.dp_v      = r_dp_v;
  assign dp.dp_i      = r_dp_i;
  assign dp.spk_valid = !w_empty;
  assign dp.spk_idx   = w_empty ? '0 : r_fifo[r_rp[PW-1:0]];
  assign dp.spk_drop  = r_drop;

endmodule
